// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the execute-side
// instruction handshake, redirect request and trap/status outputs.
//   master : the fetch unit (drives imem request, ir/ir_pc/ir_valid, pc, fault,
//            bad_vaddr, fetch_count; receives imem_rdata, ir_ready, redirect)
//   slave  : memory + execute side (the reverse directions)
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir;
  logic [31:0]       ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       pc;
  logic              fault;
  logic [31:0]       bad_vaddr;
  logic [31:0]       fetch_count;

  modport master (
    output imem_rd_en, imem_addr, ir, ir_pc, ir_valid, pc, fault, bad_vaddr, fetch_count,
    input  imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_rd_en, imem_addr, ir, ir_pc, ir_valid, pc, fault, bad_vaddr, fetch_count,
    output imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the PC, reads one 32-bit word per instruction
// from a synchronous-read instruction memory and hands it to execute over a
// valid/ready handshake. Accepts redirects from execute and traps on
// misaligned or out-of-range fetch addresses (sticky until reset).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_fetch_unit_if.master (imem port, ir handshake, redirect, status)
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {StReq, StResp, StValid, StFault} state_e;

  localparam logic [31:0] PcLimit = 32'(4 * DEPTH);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_ir_pc;
  logic        r_ir_valid;
  logic        r_fault;
  logic [31:0] r_bad_vaddr;
  logic [31:0] r_fetch_count;

  logic        w_legal;

  assign w_legal = (r_pc[1:0] == 2'b00) && (r_pc < PcLimit);

  // The read is issued whenever REQ sees a legal pc; a simultaneous redirect
  // simply leaves the returned word unused.
  assign bus.imem_rd_en  = (r_state == StReq) && w_legal;
  assign bus.imem_addr   = r_pc[ADDR_W+1:2];

  assign bus.ir          = r_ir;
  assign bus.ir_pc       = r_ir_pc;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.pc          = r_pc;
  assign bus.fault       = r_fault;
  assign bus.bad_vaddr   = r_bad_vaddr;
  assign bus.fetch_count = r_fetch_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StReq;
      r_pc          <= RESET_PC;
      r_ir          <= 32'h0;
      r_ir_pc       <= 32'h0;
      r_ir_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_bad_vaddr   <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      unique case (r_state)
        StReq: begin
          if (bus.redirect) begin
            r_pc    <= bus.redirect_pc;
            r_state <= StReq;
          end else if (w_legal) begin
            r_state <= StResp;
          end else begin
            r_bad_vaddr <= r_pc;
            r_fault     <= 1'b1;
            r_state     <= StFault;
          end
        end
        StResp: begin
          if (bus.redirect) begin
            r_pc    <= bus.redirect_pc;
            r_state <= StReq;
          end else begin
            r_ir       <= bus.imem_rdata;
            r_ir_pc    <= r_pc;
            r_pc       <= r_pc + 32'd4;
            r_ir_valid <= 1'b1;
            r_state    <= StValid;
          end
        end
        StValid: begin
          // A redirect together with ir_ready retires the branch itself.
          if (bus.ir_ready) begin
            r_fetch_count <= r_fetch_count + 32'd1;
          end
          if (bus.redirect) begin
            r_pc       <= bus.redirect_pc;
            r_ir_valid <= 1'b0;
            r_state    <= StReq;
          end else if (bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_state    <= StReq;
          end
        end
        StFault: begin
          r_state <= StFault;
        end
        default: begin
          r_state <= StReq;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  logic clk;
  logic rst;
  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [DEPTH];
  int n_cmp;
  int n_err;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until ir_valid is seen, bounded.
  task automatic wait_valid(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      tick();
      n++;
      if (bus.ir_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset(input string tag);
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.ir !== 32'h0) begin n_err++;
      $display("FAIL %s_ir: got %h want 0", tag, bus.ir); end
    n_cmp++; if (bus.ir_pc !== 32'h0) begin n_err++;
      $display("FAIL %s_ir_pc: got %h want 0", tag, bus.ir_pc); end
    n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++;
      $display("FAIL %s_ir_valid: got %b want 0", tag, bus.ir_valid); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++;
      $display("FAIL %s_fault: got %b want 0", tag, bus.fault); end
    n_cmp++; if (bus.bad_vaddr !== 32'h0) begin n_err++;
      $display("FAIL %s_bad_vaddr: got %h want 0", tag, bus.bad_vaddr); end
    n_cmp++; if (bus.fetch_count !== 32'h0) begin n_err++;
      $display("FAIL %s_count: got %0d want 0", tag, bus.fetch_count); end
    n_cmp++; if (bus.pc !== 32'h0) begin n_err++;
      $display("FAIL %s_pc: got %h want 0", tag, bus.pc); end
    n_cmp++; if (bus.imem_rd_en !== 1'b1) begin n_err++;
      $display("FAIL %s_rd_en: got %b want 1", tag, bus.imem_rd_en); end
    rst = 1'b0;
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
  endtask

  task automatic test_sequential();
    int n;
    bit ok;
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n, ok);
      // One consume edge plus these two gives a 3-cycle cadence.
      n_cmp++; if (!ok || n != 2) begin n_err++;
        $display("FAIL seq_latency[%0d]: got %0d cycles (seen=%b) want 2", i, n, ok); end
      n_cmp++; if (bus.ir !== mem[exp_pc[9:2]] || bus.ir_pc !== exp_pc) begin n_err++;
        $display("FAIL seq_ir[%0d]: got %h/%h want %h/%h", i, bus.ir, bus.ir_pc,
                 mem[exp_pc[9:2]], exp_pc); end
      tick();
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
      n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++;
        $display("FAIL seq_valid_drop[%0d]: got %b want 0", i, bus.ir_valid); end
    end
    n_cmp++; if (bus.fetch_count !== 32'd3) begin n_err++;
      $display("FAIL seq_count: got %0d want 3", bus.fetch_count); end
    bus.ir_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    int hold;
    for (int i = 0; i < 4; i++) begin
      bus.ir_ready = 1'b0;
      wait_valid(n, ok);
      n_cmp++; if (!ok || bus.ir !== mem[exp_pc[9:2]] || bus.ir_pc !== exp_pc) begin n_err++;
        $display("FAIL bp_ir[%0d]: got %h/%h want %h/%h", i, bus.ir, bus.ir_pc,
                 mem[exp_pc[9:2]], exp_pc); end
      hold = (i == 0) ? 5 : int'($urandom_range(1, 6));
      for (int k = 0; k < hold; k++) begin
        tick();
        n_cmp++;
        if (bus.ir_valid !== 1'b1 || bus.ir !== mem[exp_pc[9:2]] || bus.ir_pc !== exp_pc ||
            bus.imem_rd_en !== 1'b0 || bus.fetch_count !== exp_cnt) begin
          n_err++;
          $display("FAIL bp_hold[%0d.%0d]: got v=%b ir=%h pc=%h rd=%b cnt=%0d want v=1 ir=%h pc=%h rd=0 cnt=%0d",
                   i, k, bus.ir_valid, bus.ir, bus.ir_pc, bus.imem_rd_en, bus.fetch_count,
                   mem[exp_pc[9:2]], exp_pc, exp_cnt);
        end
      end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      exp_pc  = exp_pc + 32'd4;
      n_cmp++; if (bus.fetch_count !== exp_cnt || bus.ir_valid !== 1'b0) begin n_err++;
        $display("FAIL bp_release[%0d]: got cnt=%0d v=%b want cnt=%0d v=0", i,
                 bus.fetch_count, bus.ir_valid, exp_cnt); end
    end
  endtask

  // st: 0 = redirect in REQ, 1 = in RESP, 2 = in VALID (ir_ready low).
  task automatic test_redirect_states();
    int n;
    bit ok;
    int st;
    logic [31:0] tgt;
    logic [31:0] sv_ir;
    logic [31:0] sv_pc;
    for (int r = 0; r < 9; r++) begin
      st  = (r < 3) ? r : int'($urandom_range(0, 2));
      tgt = (r < 3) ? 32'h40 : $urandom_range(0, DEPTH - 1) * 4;
      bus.ir_ready = 1'b0;
      if (st == 1) tick();
      if (st == 2) begin
        wait_valid(n, ok);
        n_cmp++; if (!ok || bus.ir_pc !== exp_pc) begin n_err++;
          $display("FAIL redir_pre[%0d]: got pc=%h want %h", r, bus.ir_pc, exp_pc); end
      end
      sv_ir = bus.ir;
      sv_pc = bus.ir_pc;
      bus.redirect    = 1'b1;
      bus.redirect_pc = tgt;
      tick();
      bus.redirect = 1'b0;
      n_cmp++;
      if (bus.pc !== tgt || bus.ir_valid !== 1'b0 || bus.fetch_count !== exp_cnt) begin
        n_err++;
        $display("FAIL redir_edge[%0d] st=%0d: got pc=%h v=%b cnt=%0d want pc=%h v=0 cnt=%0d",
                 r, st, bus.pc, bus.ir_valid, bus.fetch_count, tgt, exp_cnt);
      end
      if (st == 1) begin
        n_cmp++; if (bus.ir !== sv_ir || bus.ir_pc !== sv_pc) begin n_err++;
          $display("FAIL redir_resp_discard[%0d]: got %h/%h want %h/%h", r, bus.ir,
                   bus.ir_pc, sv_ir, sv_pc); end
      end
      wait_valid(n, ok);
      n_cmp++;
      if (!ok || n != 2 || bus.ir !== mem[tgt[9:2]] || bus.ir_pc !== tgt) begin
        n_err++;
        $display("FAIL redir_target[%0d] st=%0d: got %h/%h after %0d want %h/%h after 2",
                 r, st, bus.ir, bus.ir_pc, n, mem[tgt[9:2]], tgt);
      end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      exp_pc  = tgt + 32'd4;
      n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_err++;
        $display("FAIL redir_count[%0d]: got %0d want %0d", r, bus.fetch_count, exp_cnt); end
    end
  endtask

  task automatic test_redirect_ready();
    int n;
    bit ok;
    logic [31:0] tgt;
    for (int r = 0; r < 3; r++) begin
      tgt = $urandom_range(0, DEPTH - 1) * 4;
      wait_valid(n, ok);
      n_cmp++; if (!ok || bus.ir_pc !== exp_pc) begin n_err++;
        $display("FAIL rr_pre[%0d]: got pc=%h want %h", r, bus.ir_pc, exp_pc); end
      bus.ir_ready    = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = tgt;
      tick();
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      n_cmp++; if (bus.fetch_count !== exp_cnt || bus.ir_valid !== 1'b0) begin n_err++;
        $display("FAIL rr_count[%0d]: got cnt=%0d v=%b want cnt=%0d v=0", r,
                 bus.fetch_count, bus.ir_valid, exp_cnt); end
      wait_valid(n, ok);
      n_cmp++; if (!ok || bus.ir_pc !== tgt || bus.ir !== mem[tgt[9:2]]) begin n_err++;
        $display("FAIL rr_target[%0d]: got %h/%h want %h/%h", r, bus.ir, bus.ir_pc,
                 mem[tgt[9:2]], tgt); end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      exp_pc  = tgt + 32'd4;
    end
  endtask

  task automatic test_trap_misaligned();
    int n;
    bit ok;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h42;
    tick();
    bus.redirect = 1'b0;
    n_cmp++; if (bus.pc !== 32'h42 || bus.imem_rd_en !== 1'b0) begin n_err++;
      $display("FAIL mis_req: got pc=%h rd=%b want pc=00000042 rd=0", bus.pc, bus.imem_rd_en); end
    tick();
    n_cmp++;
    if (bus.fault !== 1'b1 || bus.bad_vaddr !== 32'h42 || bus.ir_valid !== 1'b0 ||
        bus.imem_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL mis_trap: got f=%b bv=%h v=%b rd=%b want f=1 bv=00000042 v=0 rd=0",
               bus.fault, bus.bad_vaddr, bus.ir_valid, bus.imem_rd_en);
    end
    // Redirect and ready must be ignored while faulted.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    bus.ir_ready    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (bus.fault !== 1'b1 || bus.pc !== 32'h42 || bus.imem_rd_en !== 1'b0 ||
          bus.ir_valid !== 1'b0 || bus.fetch_count !== exp_cnt) begin
        n_err++;
        $display("FAIL mis_sticky[%0d]: got f=%b pc=%h rd=%b v=%b cnt=%0d want 1/00000042/0/0/%0d",
                 k, bus.fault, bus.pc, bus.imem_rd_en, bus.ir_valid, bus.fetch_count, exp_cnt);
      end
    end
    bus.redirect = 1'b0;
    bus.ir_ready = 1'b0;
    test_reset("rst_in_fault");
    wait_valid(n, ok);
    n_cmp++; if (!ok || bus.ir_pc !== 32'h0 || bus.ir !== mem[0]) begin n_err++;
      $display("FAIL fault_refetch: got %h/%h want %h/00000000", bus.ir, bus.ir_pc, mem[0]); end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    exp_pc  = 32'h4;
  endtask

  task automatic test_trap_end();
    int n;
    bit ok;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h3F4;
    tick();
    bus.redirect = 1'b0;
    exp_pc = 32'h3F4;
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n, ok);
      n_cmp++; if (!ok || bus.ir_pc !== exp_pc || bus.ir !== mem[exp_pc[9:2]]) begin n_err++;
        $display("FAIL end_ir[%0d]: got %h/%h want %h/%h", i, bus.ir, bus.ir_pc,
                 mem[exp_pc[9:2]], exp_pc); end
      tick();
      exp_pc  = exp_pc + 32'd4;
      exp_cnt = exp_cnt + 32'd1;
    end
    n_cmp++; if (bus.pc !== 32'h400 || bus.imem_rd_en !== 1'b0) begin n_err++;
      $display("FAIL end_req: got pc=%h rd=%b want pc=00000400 rd=0", bus.pc, bus.imem_rd_en); end
    tick();
    n_cmp++;
    if (bus.fault !== 1'b1 || bus.bad_vaddr !== 32'h400 || bus.fetch_count !== exp_cnt) begin
      n_err++;
      $display("FAIL end_trap: got f=%b bv=%h cnt=%0d want f=1 bv=00000400 cnt=%0d",
               bus.fault, bus.bad_vaddr, bus.fetch_count, exp_cnt);
    end
    bus.ir_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    wait_valid(n, ok);
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    tick();  // now in RESP with a read in flight
    test_reset("rst_in_resp");
    wait_valid(n, ok);
    n_cmp++;
    if (!ok || n != 2 || bus.ir_pc !== 32'h0 || bus.ir !== mem[0]) begin
      n_err++;
      $display("FAIL resp_refetch: got %h/%h after %0d want %h/00000000 after 2",
               bus.ir, bus.ir_pc, n, mem[0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom | 32'h1;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    rst             = 1'b1;
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_rdata  = 32'h0;
    tick();
    tick();
    test_reset("por");
    test_sequential();
    test_backpressure();
    test_redirect_states();
    test_redirect_ready();
    test_trap_misaligned();
    test_trap_end();
    test_reset("post_trap");
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
